evt_pkt_arbiter: RTL and testbench
==================================

Name: evt_pkt_arbiter

Overview:
- Round-robin, burst-limited arbiter that shares the single 72-bit peripheral-packet input of evt_dispatcher between NUM_IN packet sources (e.g. several receivers or sensor links).
- Sits directly upstream of evt_dispatcher: its output drives pkt_data_in / pkt_vld_in, and it takes back pkt_rdy_out.
- Output is a registered single-slot stage, so it adds no combinational path from the sources to the dispatcher.

Parameters:
- NUM_IN, 4, number of requesting packet sources (2..16).
- PACKET_BITS, 72, packet width; matches evt_dispatcher.
- MAX_BURST, 4, maximum consecutive packets granted to one source while other sources are requesting (1..255).

Ports:
- clk_tb  in  1  clock.
- reset_tb  in  1  reset: asynchronous, active-high.
- pkt_data_in  in  NUM_IN*PACKET_BITS  source packets; source i occupies bits [i*PACKET_BITS +: PACKET_BITS].
- pkt_vld_in  in  NUM_IN  per-source valid.
- pkt_rdy_out  out  NUM_IN  per-source ready; one-hot or all-zero.
- pkt_data_out  out  PACKET_BITS  packet to evt_dispatcher.
- pkt_vld_out  out  1  valid to evt_dispatcher.
- pkt_rdy_in  in  1  ready from evt_dispatcher.
- src_id_out  out  $clog2(NUM_IN)  index of the source that supplied pkt_data_out.

Behaviour:
- Reset values:
  - pkt_vld_out=0, pkt_data_out=0, src_id_out=0.
  - Internal pointer ptr=0, burst counter bcnt=0.
  - pkt_rdy_out=0 while reset_tb is high.
- Output slot:
  - load = ~pkt_vld_out | pkt_rdy_in.
  - pkt_vld_out/data/src_id hold stable while pkt_vld_out & ~pkt_rdy_in (AXI-stream rules; no data change under stall).
  - On pkt_vld_out & pkt_rdy_in with no new winner: pkt_vld_out <= 0.
- Winner selection (combinational, evaluated every cycle):
  - keep = pkt_vld_in[ptr] & (bcnt < MAX_BURST).
  - If keep: winner = ptr.
  - Else: winner = first i with pkt_vld_in[i]=1, scanning ptr+1, ptr+2, … modulo NUM_IN, ending with ptr itself.
  - If no source is valid: no winner.
- Handshake:
  - pkt_rdy_out[winner] = load; every other bit is 0.
  - pkt_rdy_out never depends on pkt_vld_out of another cycle beyond load.
- Transfer (winner exists & load), at the clock edge:
  - pkt_data_out <= source data; src_id_out <= winner; pkt_vld_out <= 1.
  - If winner == ptr: bcnt <= bcnt + 1.
  - Else: ptr <= winner, bcnt <= 1.
- Burst exhaustion:
  - When bcnt == MAX_BURST and another source is valid, the next winner is another source (fairness).
  - If only ptr is valid, scan wrap-around re-selects ptr; treat this as a new grant with bcnt <= 1.
- Throughput and latency:
  - One packet per cycle when pkt_rdy_in is held high.
  - Latency source handshake -> pkt_vld_out is 1 cycle.
- Width rules:
  - bcnt is 8 bits, never exceeds MAX_BURST.
  - ptr wraps modulo NUM_IN (NUM_IN need not be a power of 2).
- Boundary conditions:
  - Source drops vld mid-burst: next scan starts from ptr+1; ptr/bcnt update only on transfer.
  - All sources idle: ptr/bcnt held.
  - Reset asserted mid-transfer: slot emptied immediately (asynchronous), packet lost, pkt_rdy_out forced 0.

Optional Feature:
- Macro: EVT_PKT_ARB_GRANT_CNT_EN.
- Defined:
  - Adds output grant_cnt_out, NUM_IN*16 bits: per-source 16-bit saturating counters of accepted packets.
  - Counter i increments on pkt_vld_in[i] & pkt_rdy_out[i], sticks at 16'hFFFF, and is cleared by reset_tb.
  - Adds input grant_cnt_clr_in (1 bit), a synchronous clear of all counters; clear wins over a simultaneous increment.
- Not defined: both ports and all counter logic are absent; behaviour is otherwise identical.

Test Plan:
- NUM_IN=4, MAX_BURST=4, only source 2 valid, pkt_rdy_in=1 -> one packet per cycle, src_id_out=2 throughout, packets in order, 1-cycle latency.
- All 4 sources continuously valid, pkt_rdy_in=1 -> grant pattern 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0…; exactly 4 grants per source per 16 cycles.
- Sources 0 and 3 valid, pkt_rdy_in toggled 1,0,1,0 -> pkt_data_out stable while stalled; no packet dropped or duplicated; grants 0×4 then 3×4.
- Source 1 burst interrupted after 2 packets (vld low 3 cycles) while source 3 valid -> source 3 granted next, ptr=3, bcnt=1.
- reset_tb asserted with pkt_vld_out=1 -> pkt_vld_out=0 and pkt_rdy_out=0 immediately; after release, first grant goes to the lowest valid index at or after 0.
- With EVT_PKT_ARB_GRANT_CNT_EN: 70000 packets from source 0 -> grant_cnt_out[15:0]=16'hFFFF; grant_cnt_clr_in pulse -> all counters read 0 next cycle.

Source files
------------

// File: rtl/evt_pkt_arbiter.sv
// rtl/evt_pkt_arbiter.sv - round-robin burst-limited packet arbiter feeding evt_dispatcher
//
// Purpose:
//   Shares one PACKET_BITS-wide packet path between NUM_IN sources. A source keeps
//   the grant for up to MAX_BURST back-to-back packets while it stays valid; after
//   that, or when it goes idle, the search resumes at the next index (round robin).
//   The output is a single registered slot, so no combinational path runs from the
//   sources to the consumer.
//
// Ports:
//   clk_tb, reset_tb   clock; asynchronous active-high reset
//   pkt_data_in        NUM_IN packets, source i at [i*PACKET_BITS +: PACKET_BITS]
//   pkt_vld_in         per-source valid
//   pkt_rdy_out        per-source ready (one-hot or zero)
//   pkt_data_out       registered packet towards the dispatcher
//   pkt_vld_out        registered valid towards the dispatcher
//   pkt_rdy_in         ready from the dispatcher
//   src_id_out         source index of the packet in the slot
//
// Optional (macro EVT_PKT_ARB_GRANT_CNT_EN):
//   grant_cnt_clr_in   synchronous clear of all grant counters
//   grant_cnt_out      NUM_IN x 16-bit saturating accepted-packet counters

module evt_pkt_arbiter #(
  parameter int NUM_IN      = 4,
  parameter int PACKET_BITS = 72,
  parameter int MAX_BURST   = 4
) (
  input  logic                          clk_tb,
  input  logic                          reset_tb,
  input  logic [NUM_IN*PACKET_BITS-1:0] pkt_data_in,
  input  logic [NUM_IN-1:0]             pkt_vld_in,
  output logic [NUM_IN-1:0]             pkt_rdy_out,
  output logic [PACKET_BITS-1:0]        pkt_data_out,
  output logic                          pkt_vld_out,
  input  logic                          pkt_rdy_in,
  output logic [$clog2(NUM_IN)-1:0]     src_id_out
`ifdef EVT_PKT_ARB_GRANT_CNT_EN
  ,
  input  logic                          grant_cnt_clr_in,
  output logic [NUM_IN*16-1:0]          grant_cnt_out
`endif
);

  localparam int IW = $clog2(NUM_IN);

  logic [IW-1:0]          ptr_q, ptr_d;
  logic [7:0]             bcnt_q, bcnt_d;
  logic                   vld_q, vld_d;
  logic [PACKET_BITS-1:0] data_q, data_d;
  logic [IW-1:0]          src_q, src_d;

  logic                   keep;
  logic                   load;
  logic                   win_vld;
  logic [IW-1:0]          win_idx;
  logic [PACKET_BITS-1:0] win_data;
  int                     scan_idx;

  assign load = ~vld_q | pkt_rdy_in;
  assign keep = pkt_vld_in[ptr_q] & (bcnt_q < 8'(MAX_BURST));

  // Winner search: stay on ptr while its burst budget lasts, otherwise scan
  // ptr+1 .. ptr (wrapping), so ptr itself is the last candidate considered.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = 0;
    if (keep) begin
      win_vld = 1'b1;
      win_idx = ptr_q;
    end else begin
      for (int k = 1; k <= NUM_IN; k++) begin
        scan_idx = int'(ptr_q) + k;
        if (scan_idx >= NUM_IN) scan_idx = scan_idx - NUM_IN;
        if (!win_vld && pkt_vld_in[IW'(scan_idx)]) begin
          win_vld = 1'b1;
          win_idx = IW'(scan_idx);
        end
      end
    end
  end

  // Packet mux, constant part-selects only.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (win_idx == IW'(i)) win_data = pkt_data_in[i*PACKET_BITS +: PACKET_BITS];
    end
  end

  // Ready is forced low while reset is held, without waiting for a clock.
  always_comb begin
    pkt_rdy_out = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      pkt_rdy_out[i] = ~reset_tb & load & win_vld & (win_idx == IW'(i));
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    bcnt_d = bcnt_q;
    vld_d  = vld_q;
    data_d = data_q;
    src_d  = src_q;
    if (win_vld && load) begin
      data_d = win_data;
      src_d  = win_idx;
      vld_d  = 1'b1;
      // A wrap-around re-selection of an exhausted ptr counts as a fresh grant.
      if (keep) begin
        bcnt_d = bcnt_q + 8'd1;
      end else begin
        ptr_d  = win_idx;
        bcnt_d = 8'd1;
      end
    end else if (vld_q && pkt_rdy_in) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_tb or posedge reset_tb) begin
    if (reset_tb) begin
      ptr_q  <= '0;
      bcnt_q <= '0;
      vld_q  <= 1'b0;
      data_q <= '0;
      src_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      bcnt_q <= bcnt_d;
      vld_q  <= vld_d;
      data_q <= data_d;
      src_q  <= src_d;
    end
  end

  assign pkt_vld_out  = vld_q;
  assign pkt_data_out = data_q;
  assign src_id_out   = src_q;

`ifdef EVT_PKT_ARB_GRANT_CNT_EN
  logic [15:0] cnt_q [NUM_IN];

  always_ff @(posedge clk_tb or posedge reset_tb) begin
    if (reset_tb) begin
      for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= '0;
    end else if (grant_cnt_clr_in) begin
      for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (pkt_vld_in[i] && pkt_rdy_out[i] && (cnt_q[i] != 16'hFFFF)) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    grant_cnt_out = '0;
    for (int i = 0; i < NUM_IN; i++) grant_cnt_out[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_evt_pkt_arbiter.sv
// tb/tb_evt_pkt_arbiter.sv - self-checking bench for evt_pkt_arbiter

module tb_evt_pkt_arbiter;

  localparam int N  = 4;
  localparam int PB = 72;
  localparam int MB = 4;

  logic              clk_tb = 1'b0;
  logic              reset_tb;
  logic [N*PB-1:0]   pkt_data_in;
  logic [N-1:0]      pkt_vld_in;
  logic [N-1:0]      pkt_rdy_out;
  logic [PB-1:0]     pkt_data_out;
  logic              pkt_vld_out;
  logic              pkt_rdy_in;
  logic [$clog2(N)-1:0] src_id_out;
`ifdef EVT_PKT_ARB_GRANT_CNT_EN
  logic              grant_cnt_clr_in;
  logic [N*16-1:0]   grant_cnt_out;
`endif

  evt_pkt_arbiter #(.NUM_IN(N), .PACKET_BITS(PB), .MAX_BURST(MB)) dut (
    .clk_tb       (clk_tb),
    .reset_tb     (reset_tb),
    .pkt_data_in  (pkt_data_in),
    .pkt_vld_in   (pkt_vld_in),
    .pkt_rdy_out  (pkt_rdy_out),
    .pkt_data_out (pkt_data_out),
    .pkt_vld_out  (pkt_vld_out),
    .pkt_rdy_in   (pkt_rdy_in),
    .src_id_out   (src_id_out)
`ifdef EVT_PKT_ARB_GRANT_CNT_EN
    ,
    .grant_cnt_clr_in (grant_cnt_clr_in),
    .grant_cnt_out    (grant_cnt_out)
`endif
  );

  always #5 clk_tb = ~clk_tb;

  // Reference model: round-robin owner, packets granted in its current burst,
  // and the content of the output slot.
  int            m_ptr, m_bcnt, m_src;
  bit            m_vld;
  logic [PB-1:0] m_data;
  logic [PB-1:0] sd [N];
  int            grants [$];
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string tag, input logic [PB-1:0] obs, input logic [PB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PB-1:0] rnd72();
    return {8'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  // Winner per the arbitration rules: owner while it has budget, else the next
  // valid source going round from owner+1 and ending at owner.
  function automatic int pick(input logic [N-1:0] v, output bit kp);
    kp = v[m_ptr] && (m_bcnt < MB);
    if (kp) return m_ptr;
    for (int k = 1; k <= N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_bcnt = 0; m_vld = 0; m_data = '0; m_src = 0;
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) pkt_data_in[i*PB +: PB] = sd[i];
  endtask

  // One clock: apply inputs, check outputs mid-cycle, advance model at the edge.
  task automatic cycle(input logic [N-1:0] v, input logic r);
    int w;
    bit kp;
    bit ld;
    logic [N-1:0] er;
    pkt_vld_in = v;
    pkt_rdy_in = r;
    pack();
    #1;
    w  = pick(v, kp);
    ld = !m_vld || r;
    er = '0;
    if (w >= 0 && ld) er[w] = 1'b1;
    chk("rdy_out", PB'(pkt_rdy_out), PB'(er));
    chk("vld_out", PB'(pkt_vld_out), PB'(m_vld));
    if (m_vld) begin
      chk("data_out", pkt_data_out, m_data);
      chk("src_id", PB'(src_id_out), PB'(m_src));
    end
    @(posedge clk_tb);
    if (w >= 0 && ld) begin
      m_data = sd[w];
      m_src  = w;
      m_vld  = 1;
      grants.push_back(w);
      if (kp) m_bcnt++;
      else begin m_ptr = w; m_bcnt = 1; end
      sd[w] = rnd72();
    end else if (m_vld && r) begin
      m_vld = 0;
    end
    @(negedge clk_tb);
  endtask

  task automatic do_reset();
    reset_tb   = 1'b1;
    pkt_vld_in = '0;
    #1;
    @(negedge clk_tb);
    reset_tb = 1'b0;
    model_reset();
    grants.delete();
  endtask

  initial begin
    reset_tb   = 1'b1;
    pkt_vld_in = '0;
    pkt_rdy_in = 1'b0;
`ifdef EVT_PKT_ARB_GRANT_CNT_EN
    grant_cnt_clr_in = 1'b0;
`endif
    for (int i = 0; i < N; i++) sd[i] = rnd72();
    pack();
    model_reset();
    @(negedge clk_tb);
    @(negedge clk_tb);

    // Reset state, with every source requesting.
    pkt_vld_in = '1;
    pkt_rdy_in = 1'b1;
    #1;
    chk("rst_rdy_out", PB'(pkt_rdy_out), '0);
    chk("rst_vld_out", PB'(pkt_vld_out), '0);
    chk("rst_data_out", pkt_data_out, '0);
    chk("rst_src_id", PB'(src_id_out), '0);
    chk("rst_ptr", PB'(dut.ptr_q), '0);
    chk("rst_bcnt", PB'(dut.bcnt_q), '0);
    @(negedge clk_tb);
    do_reset();

    // Only source 2: one packet per cycle, always src 2.
    for (int k = 0; k < 10; k++) cycle(4'b0100, 1'b1);
    for (int k = 0; k < 10; k++) chk("s2_grant", PB'(grants[k]), PB'(2));
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);

    // All valid: 0x4, 1x4, 2x4, 3x4, ...
    do_reset();
    for (int k = 0; k < 32; k++) cycle(4'b1111, 1'b1);
    for (int k = 0; k < 32; k++) chk("rr_pattern", PB'(grants[k]), PB'((k / MB) % N));

    // Sources 0 and 3 with ready toggling: grants 0x4 then 3x4, data held under stall.
    do_reset();
    for (int k = 0; k < 16; k++) cycle(4'b1001, (k % 2) == 0);
    chk("toggle_count", PB'(grants.size()), PB'(8));
    for (int k = 0; k < 8; k++) chk("toggle_grant", PB'(grants[k]), PB'(k < 4 ? 0 : 3));
    cycle(4'b0000, 1'b1);

    // Source 1 burst interrupted after 2 packets while source 3 is valid.
    do_reset();
    cycle(4'b0010, 1'b1);
    cycle(4'b0010, 1'b1);
    cycle(4'b1000, 1'b1);
    chk("intr_grant", PB'(grants[grants.size()-1]), PB'(3));
    chk("intr_ptr", PB'(dut.ptr_q), PB'(3));
    chk("intr_bcnt", PB'(dut.bcnt_q), PB'(1));
    cycle(4'b1000, 1'b1);
    cycle(4'b1010, 1'b1);
    cycle(4'b1010, 1'b1);

    // Single source past its burst limit: re-granted with a fresh count.
    do_reset();
    for (int k = 0; k < 6; k++) cycle(4'b0001, 1'b1);
    chk("solo_bcnt", PB'(dut.bcnt_q), PB'(2));

    // Reset asserted with the slot full.
    do_reset();
    cycle(4'b1111, 1'b1);
    pkt_vld_in = 4'b0110;
    pkt_rdy_in = 1'b0;
    #2;
    reset_tb = 1'b1;
    #1;
    chk("mid_rst_vld_out", PB'(pkt_vld_out), '0);
    chk("mid_rst_rdy_out", PB'(pkt_rdy_out), '0);
    @(negedge clk_tb);
    reset_tb = 1'b0;
    model_reset();
    grants.delete();
    cycle(4'b0110, 1'b1);
    chk("post_rst_grant", PB'(grants[0]), PB'(1));

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] v;
      v = N'($urandom);
      if ($urandom_range(0, 3) == 0) v = v & N'($urandom);
      cycle(v, $urandom_range(0, 3) != 0);
    end

`ifdef EVT_PKT_ARB_GRANT_CNT_EN
    do_reset();
    for (int k = 0; k < 5; k++) cycle(4'b0001, 1'b1);
    chk("cnt_small", PB'(grant_cnt_out[15:0]), PB'(5));
    for (int k = 0; k < 70000; k++) cycle(4'b0001, 1'b1);
    chk("cnt_sat", PB'(grant_cnt_out[15:0]), PB'(16'hFFFF));
    chk("cnt_others", PB'(grant_cnt_out[N*16-1:16]), '0);
    grant_cnt_clr_in = 1'b1;
    cycle(4'b0001, 1'b1);
    grant_cnt_clr_in = 1'b0;
    chk("cnt_clr", PB'(grant_cnt_out), '0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
